spram_burst_ctrl: RTL and testbench

//  Command-driven burst master for one single-port 2048x60 RAM; drives its address/wren/data pins and captures out.

---
 rtl/spram_burst_ctrl.sv | 122 ++++++++++++
 tb/tb_spram_burst_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_burst_ctrl.sv
// Burst master for one single-port RAM with a 1-cycle registered read port.
// Command, write and read streams become RAM cycles; a 2-entry buffer hides the read latency.
module spram_burst_ctrl #(
  parameter int AWIDTH    = 11,
  parameter int NUM_WORDS = 2048,
  parameter int DWIDTH    = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              done,
  output logic [AWIDTH-1:0] mem_address,
  output logic              mem_wren,
  output logic [DWIDTH-1:0] mem_data,
  input  logic [DWIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH:0]   remaining;
  logic              inflight;
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DWIDTH-1:0] fifo_q [2];

  logic              pop;
  logic              issue;
  logic [2:0]        occ;

  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
    return (a == AWIDTH'(NUM_WORDS - 1)) ? '0 : a + AWIDTH'(1);
  endfunction

  assign cmd_ready   = (state == IDLE) && !reset;
  assign wr_ready    = (state == WRITE) && !reset;
  assign mem_wren    = (state == WRITE) && wr_valid && !reset;
  assign mem_address = cur_addr;
  assign mem_data    = wr_data;

  assign rd_valid = (count != 2'd0);
  assign rd_data  = fifo_q[rd_ptr];
  assign pop      = rd_valid && rd_ready;

  // A read may only be issued if its word is guaranteed a buffer slot when it lands.
  assign occ   = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue = (state == READ) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      count    <= count + 2'(inflight) - 2'(pop);
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0)  done  <= 1'b1;
            else if (cmd_write) state <= WRITE;
            else                state <= READ;
          end
        end
        WRITE: begin
          if (mem_wren) begin
            cur_addr  <= next_addr(cur_addr);
            remaining <= remaining - (AWIDTH+1)'(1);
            if (remaining == (AWIDTH+1)'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            cur_addr  <= next_addr(cur_addr);
            remaining <= remaining - (AWIDTH+1)'(1);
            if (remaining == (AWIDTH+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Final word is leaving the buffer and nothing else is pending.
          if (pop && (count == 2'd1) && !inflight) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM output is taken only in the cycle after an issued read.
  always_ff @(posedge clk) begin
    if (inflight) fifo_q[wr_ptr] <= mem_out;
  end

endmodule

// File: tb/tb_spram_burst_ctrl.sv
// Randomized scoreboard bench for spram_burst_ctrl with a behavioural RAM and a word-array reference.
module tb_spram_burst_ctrl;
  localparam int AW = 11;
  localparam int NW = 2048;
  localparam int DW = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;

  spram_burst_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data),
    .mem_out(mem_out)
  );

  // Single-port RAM: write on wren, otherwise registered read.
  logic [DW-1:0] ram [NW];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    else          mem_out <= ram[mem_address];
  end

  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] exp_q [$];
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, pop_cnt = 0, first_rv = -1, last_pop = -1;
  int rd_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd60();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic logic [63:0] wrap(input logic [AW-1:0] a, input int i);
    return 64'((int'(a) + i) % NW);
  endfunction

  // Consumer ready: 0 always, 1 random, 2 toggle, 3 held low.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        2:       rd_ready = ~rd_ready;
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Monitor: done counting, read scoreboard, hold-while-stalled property.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (reset === 1'b0) begin
        if (prev_stall) begin
          chk("rd_hold_valid", 64'(rd_valid), 64'(1));
          chk("rd_hold_data", 64'(rd_data), 64'(prev_data));
        end
        if (rd_valid === 1'b1 && first_rv < 0) first_rv = cyc;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
          pop_cnt++;
          last_pop = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got %0h expected no beat", rd_data);
          end else begin
            chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
          end
        end
        prev_stall = (rd_valid === 1'b1) && (rd_ready === 1'b0);
        prev_data  = rd_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic do_cmd(input bit w, input logic [AW-1:0] a, input int l, output int c0);
    int n;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = (AW+1)'(l);
    n = 0;
    c0 = -1;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL cmd_timeout: got cmd_ready=0 expected 1 within 100 cycles");
        cmd_valid = 1'b0;
        return;
      end
    end
    c0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic len0_checks(input int d0);
    @(negedge clk);
    chk("len0_done", 64'(done), 64'(1));
    chk("len0_wren", 64'(mem_wren), 64'(0));
    chk("len0_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("len0_done_once", 64'(done_cnt), 64'(d0 + 1));
  endtask

  // mode: 0 continuous, 1 random gaps, 2 cycle pattern from pat.
  task automatic write_burst(input logic [AW-1:0] a, input int l, input int mode, input logic [31:0] pat);
    int i, k, c0, d0;
    logic v;
    d0 = done_cnt;
    do_cmd(1'b1, a, l, c0);
    if (l == 0) begin len0_checks(d0); return; end
    i = 0; k = 0;
    while (i < l && k < 8 * l + 64) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = (k < 32) ? pat[k] : 1'b1;
      endcase
      wr_valid = v;
      wr_data  = rnd60();
      @(negedge clk);
      chk("wr_ready", 64'(wr_ready), 64'(1));
      chk("wr_mem_wren", 64'(mem_wren), 64'(v));
      chk("wr_mem_address", 64'(mem_address), wrap(a, i));
      if (v) begin
        chk("wr_mem_data", 64'(mem_data), 64'(wr_data));
        ref_mem[(int'(a) + i) % NW] = wr_data;
        i++;
      end
      @(posedge clk); #1;
      k++;
    end
    wr_valid = 1'b0;
    if (i < l) begin
      checks++; failures++;
      $display("FAIL wr_timeout: got %0d beats expected %0d", i, l);
    end
    @(negedge clk);
    chk("wr_done_pulse", 64'(done), 64'(1));
    chk("wr_idle_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("wr_done_once", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int l, input int mode,
                            input bit lat_chk, input bit stall_chk);
    int c0, d0, p0, n;
    rd_mode = mode;
    for (int i = 0; i < l; i++) exp_q.push_back(ref_mem[(int'(a) + i) % NW]);
    first_rv = -1;
    d0 = done_cnt;
    p0 = pop_cnt;
    do_cmd(1'b0, a, l, c0);
    if (l == 0) begin len0_checks(d0); return; end
    if (stall_chk) begin
      repeat (4) @(negedge clk);
      chk("stall_addr_t4", 64'(mem_address), wrap(a, 2));
      chk("stall_wren", 64'(mem_wren), 64'(0));
      @(negedge clk);
      chk("stall_addr_t5", 64'(mem_address), wrap(a, 2));
      chk("stall_rd_valid", 64'(rd_valid), 64'(1));
      chk("stall_no_pop", 64'(pop_cnt), 64'(p0));
      rd_mode = 2;
      @(posedge clk); #1;
    end
    n = 0;
    while (done_cnt == d0 && n < 16 * l + 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      checks++; failures++;
      $display("FAIL rd_timeout: got no done expected done after %0d beats", l);
    end
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rd_done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("rd_all_beats", 64'(exp_q.size()), 64'(0));
    chk("rd_beat_count", 64'(pop_cnt - p0), 64'(l));
    if (lat_chk) begin
      chk("rd_first_valid_lat", 64'(first_rv), 64'(c0 + 3));
      chk("rd_last_pop_cycle", 64'(last_pop), 64'(c0 + 2 + l));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, d0, p0, n, l, m;
    logic [AW-1:0] a;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_mem_wren", 64'(mem_wren), 64'(0));
    chk("rst_mem_address", 64'(mem_address), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // Full-depth burst from 0x400 fills every word, then reads it all back.
    write_burst(11'h400, NW, 0, '0);
    read_burst(11'h400, NW, 1, 1'b0, 1'b0);

    write_burst(11'h010, 4, 0, '0);
    read_burst(11'h010, 4, 0, 1'b1, 1'b0);

    write_burst(11'h7FE, 4, 1, '0);
    read_burst(11'h7FE, 4, 0, 1'b1, 1'b0);

    read_burst(AW'($urandom_range(0, NW - 1)), 8, 3, 1'b0, 1'b1);

    write_burst(11'h123, 3, 2, 32'b11001);
    write_burst(11'h200, 0, 0, '0);
    read_burst(11'h123, 3, 2, 1'b0, 1'b0);

    // Reset while beat 3 of 8 is being offered.
    rd_mode = 0;
    a = 11'h050;
    for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[(int'(a) + i) % NW]);
    d0 = done_cnt;
    p0 = pop_cnt;
    do_cmd(1'b0, a, 8, c0);
    n = 0;
    while (pop_cnt < p0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_beat3", 64'(pop_cnt >= p0 + 2), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    read_burst(11'h010, 4, 0, 1'b1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      a = AW'($urandom_range(0, NW - 1));
      l = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin
        write_burst(a, l, $urandom_range(0, 1), '0);
      end else begin
        m = $urandom_range(0, 2);
        read_burst(a, l, m, (m == 0), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
